// File: rtl/switch_allocator_if.sv
// Allocator-side bundle between the input ports / RC units and the crossbar.
// Encodings: port LOCAL=0 NORTH=1 SOUTH=2 WEST=3 EAST=4; flit HEAD=0 BODY=1 TAIL=2 HEADTAIL=3.
interface switch_allocator_if #(
  parameter int PORT_NUM = 5
);
  localparam int SELW = $clog2(PORT_NUM);

  logic [PORT_NUM-1:0]           req_i;
  logic [PORT_NUM-1:0][SELW-1:0] out_port_i;
  logic [PORT_NUM-1:0][1:0]      flit_type_i;
  logic [PORT_NUM-1:0]           credit_i;
  logic [PORT_NUM-1:0]           grant_o;
  logic [PORT_NUM-1:0]           valid_o;
  logic [PORT_NUM-1:0][SELW-1:0] xbar_sel_o;

  modport master (
    output req_i, out_port_i, flit_type_i, credit_i,
    input  grant_o, valid_o, xbar_sel_o
  );

  modport slave (
    input  req_i, out_port_i, flit_type_i, credit_i,
    output grant_o, valid_o, xbar_sel_o
  );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking and credit tracking.
// Grants are combinational; lock, pointer and credit state update on the grant edge.
module switch_allocator #(
  parameter int PORT_NUM    = 5,
  parameter int BUFFER_SIZE = 8
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave sa
);
  localparam int SELW = $clog2(PORT_NUM);
  localparam int CW   = $clog2(BUFFER_SIZE + 1);

  localparam logic [1:0] FT_HEAD     = 2'd0;
  localparam logic [1:0] FT_TAIL     = 2'd2;
  localparam logic [1:0] FT_HEADTAIL = 2'd3;

  logic [SELW-1:0]     rr_ptr_q     [PORT_NUM];
  logic [SELW-1:0]     rr_ptr_d     [PORT_NUM];
  logic [PORT_NUM-1:0] lock_valid_q;
  logic [PORT_NUM-1:0] lock_valid_d;
  logic [SELW-1:0]     lock_owner_q [PORT_NUM];
  logic [SELW-1:0]     lock_owner_d [PORT_NUM];
  logic [CW-1:0]       credits_q    [PORT_NUM];
  logic [CW-1:0]       credits_d    [PORT_NUM];

  logic [PORT_NUM-1:0] win_vld;
  logic [SELW-1:0]     win_idx [PORT_NUM];

  function automatic logic is_head(input logic [1:0] ft);
    return (ft == FT_HEAD) || (ft == FT_HEADTAIL);
  endfunction

  // Arbitration: first eligible input at or after rr_ptr, wrapping modulo PORT_NUM
  always_comb begin
    logic [SELW:0]   sum;
    logic [SELW-1:0] idx;
    logic            elig;
    sum  = '0;
    idx  = '0;
    elig = 1'b0;
    for (int j = 0; j < PORT_NUM; j++) begin
      win_vld[j] = 1'b0;
      win_idx[j] = '0;
      for (int k = 0; k < PORT_NUM; k++) begin
        sum = {1'b0, rr_ptr_q[j]} + (SELW+1)'(k);
        if (sum >= (SELW+1)'(PORT_NUM)) sum = sum - (SELW+1)'(PORT_NUM);
        idx  = sum[SELW-1:0];
        elig = sa.req_i[idx] && (sa.out_port_i[idx] == SELW'(j)) && (credits_q[j] != '0) &&
               (lock_valid_q[j] ? ((lock_owner_q[j] == idx) && !is_head(sa.flit_type_i[idx]))
                                :  is_head(sa.flit_type_i[idx]));
        if (elig && !win_vld[j]) begin
          win_vld[j] = 1'b1;
          win_idx[j] = idx;
        end
      end
    end
  end

  always_comb begin
    sa.grant_o = '0;
    sa.valid_o = '0;
    for (int j = 0; j < PORT_NUM; j++) sa.xbar_sel_o[j] = '0;
    if (!rst) begin
      for (int j = 0; j < PORT_NUM; j++) begin
        if (win_vld[j]) begin
          sa.grant_o[win_idx[j]] = 1'b1;
          sa.valid_o[j]          = 1'b1;
          sa.xbar_sel_o[j]       = win_idx[j];
        end
      end
    end
  end

  // Next state: lock follows packet boundaries, pointer advances once per packet
  always_comb begin
    logic [1:0] ft;
    ft           = FT_HEAD;
    lock_valid_d = lock_valid_q;
    for (int j = 0; j < PORT_NUM; j++) begin
      rr_ptr_d[j]     = rr_ptr_q[j];
      lock_owner_d[j] = lock_owner_q[j];
      credits_d[j]    = credits_q[j];
      if (win_vld[j]) begin
        ft = sa.flit_type_i[win_idx[j]];
        if (ft == FT_HEAD) begin
          lock_valid_d[j] = 1'b1;
          lock_owner_d[j] = win_idx[j];
        end else if (ft == FT_TAIL) begin
          lock_valid_d[j] = 1'b0;
        end
        if (is_head(ft)) begin
          rr_ptr_d[j] = (win_idx[j] == SELW'(PORT_NUM - 1)) ? '0 : win_idx[j] + SELW'(1);
        end
      end
      if (win_vld[j] && !sa.credit_i[j]) begin
        credits_d[j] = credits_q[j] - CW'(1);
      end else if (!win_vld[j] && sa.credit_i[j] && (credits_q[j] != CW'(BUFFER_SIZE))) begin
        credits_d[j] = credits_q[j] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_valid_q <= '0;
      for (int j = 0; j < PORT_NUM; j++) begin
        rr_ptr_q[j]     <= '0;
        lock_owner_q[j] <= '0;
        credits_q[j]    <= CW'(BUFFER_SIZE);
      end
    end else begin
      lock_valid_q <= lock_valid_d;
      for (int j = 0; j < PORT_NUM; j++) begin
        rr_ptr_q[j]     <= rr_ptr_d[j];
        lock_owner_q[j] <= lock_owner_d[j];
        credits_q[j]    <= credits_d[j];
      end
    end
  end
endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed vector table, hand sequences for credit and
// reset corner cases, then randomized packet traffic against a behavioural model.
module tb_switch_allocator;
  localparam int P = 5;
  localparam int B = 8;
  localparam logic [1:0] HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HT = 2'd3;
  localparam logic [2:0] LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, WEST = 3'd3, EAST = 3'd4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_allocator_if #(.PORT_NUM(P)) sa_if ();
  switch_allocator #(.PORT_NUM(P), .BUFFER_SIZE(B)) dut (.clk(clk), .rst(rst), .sa(sa_if.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  int m_cred [P];
  bit m_lock [P];
  int m_owner[P];
  int m_ptr  [P];
  logic [P-1:0]      e_grant, e_valid;
  logic [P-1:0][2:0] e_sel;

  typedef struct {
    logic [4:0]  req;
    logic [14:0] op;
    logic [9:0]  ft;
    logic [4:0]  cr;
    logic [4:0]  g;
    logic [4:0]  v;
    logic [14:0] sel;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [14:0] at3(input int i, input logic [2:0] val);
    logic [14:0] r;
    r = '0;
    r[i*3 +: 3] = val;
    return r;
  endfunction

  function automatic logic [9:0] at2(input int i, input logic [1:0] val);
    logic [9:0] r;
    r = '0;
    r[i*2 +: 2] = val;
    return r;
  endfunction

  function automatic void model_eval();
    e_grant = '0;
    e_valid = '0;
    e_sel   = '0;
    if (rst) return;
    for (int j = 0; j < P; j++) begin
      int best, bestd;
      best = -1;
      bestd = P;
      for (int i = 0; i < P; i++) begin
        logic [1:0] ft;
        bit ok;
        ft = sa_if.flit_type_i[i];
        ok = sa_if.req_i[i] && (int'(sa_if.out_port_i[i]) == j) && (m_cred[j] > 0);
        if (m_lock[j]) ok = ok && (m_owner[j] == i) && (ft == BODY || ft == TAIL);
        else           ok = ok && (ft == HEAD || ft == HT);
        // distance from the pointer in round-robin order
        if (ok && ((i - m_ptr[j] + P) % P) < bestd) begin
          best = i;
          bestd = (i - m_ptr[j] + P) % P;
        end
      end
      if (best >= 0) begin
        e_grant[best] = 1'b1;
        e_valid[j]    = 1'b1;
        e_sel[j]      = 3'(best);
      end
    end
  endfunction

  function automatic void model_update();
    for (int j = 0; j < P; j++) begin
      if (rst) begin
        m_cred[j] = B; m_lock[j] = 0; m_owner[j] = 0; m_ptr[j] = 0;
      end else begin
        if (e_valid[j]) begin
          int i;
          logic [1:0] ft;
          i  = int'(e_sel[j]);
          ft = sa_if.flit_type_i[i];
          if (ft == HEAD) begin m_lock[j] = 1; m_owner[j] = i; end
          if (ft == TAIL) m_lock[j] = 0;
          if (ft == HEAD || ft == HT) m_ptr[j] = (i + 1) % P;
        end
        if (e_valid[j] && !sa_if.credit_i[j]) m_cred[j] = m_cred[j] - 1;
        else if (!e_valid[j] && sa_if.credit_i[j] && m_cred[j] < B) m_cred[j] = m_cred[j] + 1;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r, input logic [14:0] op, input logic [9:0] ft,
                       input logic [4:0] cr);
    sa_if.req_i       = r;
    sa_if.out_port_i  = op;
    sa_if.flit_type_i = ft;
    sa_if.credit_i    = cr;
  endtask

  // Called at posedge+1 with inputs already driven; checks mid-cycle, then crosses one edge.
  task automatic tick(input string tag, input bit hand, input logic [4:0] hg,
                      input logic [4:0] hv, input logic [14:0] hs);
    #3;
    model_eval();
    chk({tag, " grant"}, 32'(sa_if.grant_o), 32'(e_grant));
    chk({tag, " valid"}, 32'(sa_if.valid_o), 32'(e_valid));
    chk({tag, " xbar"},  32'(sa_if.xbar_sel_o), 32'(e_sel));
    if (hand) begin
      chk({tag, " grant/vec"}, 32'(sa_if.grant_o), 32'(hg));
      chk({tag, " valid/vec"}, 32'(sa_if.valid_o), 32'(hv));
      chk({tag, " xbar/vec"},  32'(sa_if.xbar_sel_o), 32'(hs));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  // random packet generator state per input
  int         g_pos[P], g_len[P];
  logic [2:0] g_dst[P];

  initial begin
    logic [14:0] nop, wop, eop, lop;
    logic [9:0]  nft;
    nop = at3(0, NORTH) | at3(2, NORTH) | at3(4, NORTH);
    nft = at2(0, HT) | at2(2, HT) | at2(4, HT);
    tbl[0]  = '{5'b00010, at3(1, EAST), at2(1, HT), 5'b0, 5'b00010, 5'b10000, at3(4, 3'd1)};
    tbl[1]  = '{5'b10101, nop, nft, 5'b0, 5'b00001, 5'b00010, 15'd0};
    tbl[2]  = '{5'b10101, nop, nft, 5'b0, 5'b00100, 5'b00010, at3(1, 3'd2)};
    tbl[3]  = '{5'b10101, nop, nft, 5'b0, 5'b10000, 5'b00010, at3(1, 3'd4)};
    tbl[4]  = '{5'b10101, nop, nft, 5'b0, 5'b00001, 5'b00010, 15'd0};
    tbl[5]  = '{5'b00100, at3(2, SOUTH), at2(2, HT), 5'b0, 5'b00100, 5'b00100, at3(2, 3'd2)};
    tbl[6]  = '{5'b01001, at3(0, SOUTH) | at3(3, SOUTH), at2(3, HEAD), 5'b0,
                5'b01000, 5'b00100, at3(2, 3'd3)};
    tbl[7]  = '{5'b01001, at3(0, SOUTH) | at3(3, SOUTH), at2(3, BODY), 5'b0,
                5'b01000, 5'b00100, at3(2, 3'd3)};
    tbl[8]  = tbl[7];
    tbl[9]  = '{5'b01001, at3(0, SOUTH) | at3(3, SOUTH), at2(3, TAIL), 5'b0,
                5'b01000, 5'b00100, at3(2, 3'd3)};
    tbl[10] = '{5'b00001, at3(0, SOUTH), at2(0, HEAD), 5'b0, 5'b00001, 5'b00100, 15'd0};
    tbl[11] = '{5'b00001, at3(0, SOUTH), at2(0, TAIL), 5'b0, 5'b00001, 5'b00100, 15'd0};

    rst = 1'b1;
    drive(5'b0, 15'd0, 10'd0, 5'b0);
    @(posedge clk);
    model_update();
    #1;
    // outputs held low during reset even with live requests
    drive(5'b11111, 15'd0, 10'd0, 5'b0);
    tick("reset", 1'b1, 5'b0, 5'b0, 15'd0);
    tick("reset", 1'b1, 5'b0, 5'b0, 15'd0);
    rst = 1'b0;

    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].req, tbl[r].op, tbl[r].ft, tbl[r].cr);
      tick($sformatf("vec%0d", r), 1'b1, tbl[r].g, tbl[r].v, tbl[r].sel);
    end

    // WEST credit exhaustion and single-credit return
    wop = at3(1, WEST);
    drive(5'b00010, wop, at2(1, HT), 5'b0);
    for (int k = 0; k < 8; k++) tick("west_drain", 1'b1, 5'b00010, 5'b01000, at3(3, 3'd1));
    for (int k = 0; k < 3; k++) tick("west_empty", 1'b1, 5'b0, 5'b0, 15'd0);
    drive(5'b00010, wop, at2(1, HT), 5'b01000);
    tick("west_credit_same", 1'b1, 5'b0, 5'b0, 15'd0);
    drive(5'b00010, wop, at2(1, HT), 5'b0);
    tick("west_credit_next", 1'b1, 5'b00010, 5'b01000, at3(3, 3'd1));
    tick("west_empty2", 1'b1, 5'b0, 5'b0, 15'd0);

    // EAST: simultaneous grant and credit at 3 keeps the count at 3
    eop = at3(4, EAST);
    drive(5'b10000, eop, at2(4, HT), 5'b0);
    for (int k = 0; k < 4; k++) tick("east_to3", 1'b1, 5'b10000, 5'b10000, at3(4, 3'd4));
    drive(5'b10000, eop, at2(4, HT), 5'b10000);
    tick("east_grant_credit", 1'b1, 5'b10000, 5'b10000, at3(4, 3'd4));
    drive(5'b10000, eop, at2(4, HT), 5'b0);
    for (int k = 0; k < 3; k++) tick("east_left3", 1'b1, 5'b10000, 5'b10000, at3(4, 3'd4));
    tick("east_empty", 1'b1, 5'b0, 5'b0, 15'd0);

    // LOCAL: credit at full count saturates
    lop = at3(3, LOCAL);
    drive(5'b0, 15'd0, 10'd0, 5'b00001);
    tick("local_sat", 1'b1, 5'b0, 5'b0, 15'd0);
    drive(5'b01000, lop, at2(3, HT), 5'b0);
    for (int k = 0; k < 8; k++) tick("local_8", 1'b1, 5'b01000, 5'b00001, at3(0, 3'd3));
    tick("local_empty", 1'b1, 5'b0, 5'b0, 15'd0);

    // reset mid-packet drops the lock
    drive(5'b0, 15'd0, 10'd0, 5'b00001);
    tick("local_refill", 1'b1, 5'b0, 5'b0, 15'd0);
    tick("local_refill", 1'b1, 5'b0, 5'b0, 15'd0);
    drive(5'b00100, 15'd0, at2(2, HEAD), 5'b0);
    tick("rst_head2", 1'b1, 5'b00100, 5'b00001, at3(0, 3'd2));
    rst = 1'b1;
    drive(5'b00110, 15'd0, at2(2, BODY), 5'b0);
    tick("rst_active", 1'b1, 5'b0, 5'b0, 15'd0);
    tick("rst_active", 1'b1, 5'b0, 5'b0, 15'd0);
    rst = 1'b0;
    drive(5'b00010, 15'd0, 10'd0, 5'b0);
    tick("rst_head1", 1'b1, 5'b00010, 5'b00001, at3(0, 3'd1));

    // randomized packet traffic
    for (int i = 0; i < P; i++) begin g_pos[i] = 0; g_len[i] = 0; g_dst[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      logic [4:0]  r, cr;
      logic [14:0] op;
      logic [9:0]  ft;
      r = '0; cr = '0; op = '0; ft = '0;
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < P; i++) begin
        logic [1:0] f;
        if (g_pos[i] >= g_len[i]) begin
          g_len[i] = $urandom_range(1, 4);
          g_pos[i] = 0;
          g_dst[i] = 3'($urandom_range(0, P - 1));
        end
        if (g_len[i] == 1)               f = HT;
        else if (g_pos[i] == 0)          f = HEAD;
        else if (g_pos[i] == g_len[i]-1) f = TAIL;
        else                             f = BODY;
        if ($urandom_range(0, 19) == 0) f = 2'($urandom_range(0, 3));
        r[i] = ($urandom_range(0, 9) < 8);
        op[i*3 +: 3] = g_dst[i];
        ft[i*2 +: 2] = f;
        cr[i] = ($urandom_range(0, 9) < 3);
      end
      drive(r, op, ft, cr);
      tick("rand", 1'b0, 5'b0, 5'b0, 15'd0);
      for (int i = 0; i < P; i++) begin
        if (rst) g_pos[i] = g_len[i];
        else if (e_grant[i]) g_pos[i]++;
      end
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Switch allocator for the 5-port mesh router. Each cycle it matches the head flits waiting in the input ports to router output ports, then drives the crossbar select lines and the input-port pop grants. It runs one round-robin arbiter per output, holds an output for the full length of a multi-flit packet (wormhole lock), and tracks downstream buffer credits per output. It sits between the input ports / RC units and the crossbar.

## Interface
- PORT_NUM, 5: number of router ports (LOCAL, NORTH, SOUTH, WEST, EAST, indexed by `port_t` value).
- BUFFER_SIZE, 8: downstream input-buffer depth; initial credit count per output.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_i  input  PORT_NUM  input i has a valid flit at its buffer head.
- out_port_i  input  PORT_NUM x port_t  RC-computed output for input i's flit.
- flit_type_i  input  PORT_NUM x flit_type_t  HEAD / BODY / TAIL / HEADTAIL of input i's flit.
- credit_i  input  PORT_NUM  one credit returned by the downstream router on output j this cycle.
- grant_o  output  PORT_NUM  input i's flit crosses the switch this cycle; input port pops it.
- valid_o  output  PORT_NUM  output j carries a valid flit this cycle.
- xbar_sel_o  output  PORT_NUM x $clog2(PORT_NUM)  input index driven onto output j.

## Operation
- State per output j: rr_ptr[j] (input index), lock_valid[j], lock_owner[j], credits[j] (width $clog2(BUFFER_SIZE+1)).
- Output j is eligible for input i when req_i[i], out_port_i[i]==j, credits[j]>0, and one of the following holds:
  - output j is unlocked and the flit is HEAD or HEADTAIL;
  - output j is locked, lock_owner[j]==i, and the flit is BODY or TAIL.
- Arbitration per output: the first eligible input, searching from rr_ptr[j] upward with wrap-around modulo PORT_NUM. At most one grant per output. Each input targets exactly one output, so at most one grant per input.
- Grant to input i on output j:
  - grant_o[i]=1, valid_o[j]=1, xbar_sel_o[j]=i.
  - credits[j] decrements.
  - HEAD: lock_valid[j]<=1, lock_owner[j]<=i.
  - TAIL: lock_valid[j]<=0.
  - HEADTAIL: lock unchanged (remains clear).
- rr_ptr[j]<=(i+1) mod PORT_NUM only on a HEAD or HEADTAIL grant. Fairness is per packet.
- credit_i[j]: credits[j] increments. A simultaneous grant and credit on j leaves the count unchanged. An increment at BUFFER_SIZE saturates and is otherwise ignored.
- Protocol violations are not granted and change no state:
  - BODY/TAIL request to an unlocked output, or to an output locked by another input;
  - HEAD request to an output that is locked.
- U-turn requests (out_port_i[i]==i) are treated like any other request.
- Outputs with no grant: valid_o[j]=0, xbar_sel_o[j]=0.

## Timing
- grant_o, valid_o and xbar_sel_o are combinational from the current inputs and registered state. There are zero cycles from request to grant, and one flit per input per cycle is sustainable.
- State updates take effect at the rising edge that ends the grant cycle.
- While rst=1, all outputs are forced to 0.
- At the edge with rst=1: rr_ptr=0, lock_valid=0, lock_owner=0, credits=BUFFER_SIZE. Reset mid-packet drops the lock unconditionally.
- credits[j]==0 blocks output j, including for the lock owner's BODY/TAIL flits. The lock is retained until the TAIL is granted.
- A credit arriving in cycle N enables a grant in cycle N+1, not in cycle N.

## Test plan
- Reset, then single HEADTAIL from input 1 to EAST:
  - cycle 0: grant_o=00010, valid_o[EAST]=1, xbar_sel_o[EAST]=1;
  - afterwards: credits[EAST]=7, rr_ptr[EAST]=2.
- Inputs 0, 2 and 4 each hold continuous HEADTAIL requests to NORTH: grants rotate 0, 2, 4, 0, ... on consecutive cycles, with no input skipped or repeated.
- Packet from input 3 to SOUTH (HEAD, BODY, BODY, TAIL) while input 0 sends HEAD requests to SOUTH every cycle:
  - input 3 is granted 4 consecutive cycles;
  - input 0 is granted in the 5th cycle.
- Credit exhaustion: 8 HEADTAIL grants on WEST with no credit_i, then the request persists:
  - no grant while credits=0;
  - pulse credit_i[WEST] in cycle N: grant in cycle N+1 only.
- Simultaneous credit_i and grant on EAST at credits=3: count stays 3. A credit at credits=8 stays 8.
- Reset asserted after HEAD grant of input 2 to LOCAL:
  - all outputs 0 during reset;
  - after reset, a HEAD from input 1 to LOCAL is granted immediately.
